// File: rtl/axi_single_beat_master_pkg.sv
// axi_single_beat_master_pkg: FSM states, AXI response/attribute constants and size helper
package axi_single_beat_master_pkg;
  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R, RESP, DRAIN
  } state_t;
  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [1:0] RESP_EXOKAY      = 2'b01;
  localparam logic [1:0] RESP_SLVERR      = 2'b10;
  localparam logic [1:0] RESP_DECERR      = 2'b11;
  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [3:0] CACHE_MODIFIABLE = 4'b0010;
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction
  function automatic logic resp_err(input logic [1:0] resp);
    return resp == RESP_SLVERR || resp == RESP_DECERR;
  endfunction
endpackage

// File: rtl/axi_single_beat_master.sv
// axi_single_beat_master: request/response port to single-beat AXI4 reads/writes, one outstanding.
// Optional response timeout with late-response drain: AXI_SINGLE_BEAT_MASTER_TIMEOUT_EN.
module axi_single_beat_master
  import axi_single_beat_master_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 1,
  parameter logic [AXI_ID_WIDTH-1:0] TXN_ID = '0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_strb_i,
  output logic                        rsp_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic [3:0]                  m_axi_awqos,
  output logic [3:0]                  m_axi_awregion,
  output logic [AXI_USER_WIDTH-1:0]   m_axi_awuser,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic [AXI_USER_WIDTH-1:0]   m_axi_wuser,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arlock,
  output logic [3:0]                  m_axi_arcache,
  output logic [2:0]                  m_axi_arprot,
  output logic [3:0]                  m_axi_arqos,
  output logic [3:0]                  m_axi_arregion,
  output logic [AXI_USER_WIDTH-1:0]   m_axi_aruser,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);
  state_t state, state_n;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] strb_q;
  logic aw_done, w_done, timeout, timed_out;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef AXI_SINGLE_BEAT_MASTER_TIMEOUT_EN
  logic [31:0] cnt;
  // Counter sits at zero outside the wait states, so it is already clear on entry
  assign timeout = ((state == WAIT_B && !m_axi_bvalid) || (state == WAIT_R && !m_axi_rvalid))
                   && cnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt       <= '0;
      timed_out <= 1'b0;
    end else begin
      cnt <= (state == WAIT_B || state == WAIT_R) ? cnt + 32'd1 : '0;
      if (state == WAIT_B || state == WAIT_R) timed_out <= timeout;
    end
  end
`else
  assign timeout   = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:         if (req_valid_i) state_n = req_we_i ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_n = WAIT_B;
      WAIT_B:       if (m_axi_bvalid || timeout) state_n = RESP;
      RD_ADDR:      if (m_axi_arready) state_n = WAIT_R;
      WAIT_R:       if (m_axi_rvalid || timeout) state_n = RESP;
      RESP:         state_n = timed_out ? DRAIN : IDLE;
      DRAIN:        if (m_axi_bvalid || m_axi_rvalid) state_n = IDLE;
      default:      state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state <= state_n;
      if (req_valid_i && req_ready_o) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        strb_q  <= req_strb_i;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
      if (m_axi_wvalid && m_axi_wready) w_done <= 1'b1;
      if (state == WAIT_B && m_axi_bvalid) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= resp_err(m_axi_bresp) || m_axi_bid != TXN_ID;
      end else if (state == WAIT_R && m_axi_rvalid) begin
        rsp_rdata_o <= m_axi_rdata;
        rsp_err_o   <= resp_err(m_axi_rresp) || !m_axi_rlast || m_axi_rid != TXN_ID;
      end else if (timeout) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b1;
      end
    end
  end

  assign req_ready_o   = state == IDLE;
  assign rsp_valid_o   = state == RESP;
  assign m_axi_awvalid = state == WR_ADDR_DATA && !aw_done;
  assign m_axi_wvalid  = state == WR_ADDR_DATA && !w_done;
  assign m_axi_arvalid = state == RD_ADDR;
  assign m_axi_bready  = state == WAIT_B || state == DRAIN;
  assign m_axi_rready  = state == WAIT_R || state == DRAIN;

  assign m_axi_awid     = TXN_ID;
  assign m_axi_awaddr   = addr_q;
  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = axi_size(AXI_DATA_WIDTH);
  assign m_axi_awburst  = BURST_INCR;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = CACHE_MODIFIABLE;
  assign m_axi_awprot   = 3'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_awuser   = '0;
  assign m_axi_wdata    = wdata_q;
  assign m_axi_wstrb    = strb_q;
  assign m_axi_wlast    = 1'b1;
  assign m_axi_wuser    = '0;
  assign m_axi_arid     = TXN_ID;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = 8'd0;
  assign m_axi_arsize   = axi_size(AXI_DATA_WIDTH);
  assign m_axi_arburst  = BURST_INCR;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = CACHE_MODIFIABLE;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_aruser   = '0;
endmodule

// File: doc/axi_single_beat_master.md
Name: axi_single_beat_master

Overview:
- AXI4 initiator: converts a simple request/response command port into single-beat AXI4 read/write transactions on Xilinx-style m_axi_* master ports.
- Counterpart of the peripheral wrapper's Xilinx-style slave inputs; drives PLIC/timer register slaves from boot/debug logic or a test host.
- One outstanding transaction at a time.

Parameters:
- AXI_ID_WIDTH, 10, width of awid/arid/bid/rid.
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width; strobe width is AXI_DATA_WIDTH/8.
- AXI_USER_WIDTH, 1, user signal width.
- TXN_ID, 0, constant ID driven on awid/arid.
- TIMEOUT_CYCLES, 1024, response timeout; used only with the optional feature.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  reset; one clock, reset is synchronous and active-low.
- req_valid_i  input  1  command valid.
- req_ready_o  output  1  command accepted when valid&ready.
- req_we_i  input  1  1=write, 0=read.
- req_addr_i  input  AXI_ADDR_WIDTH  byte address.
- req_wdata_i  input  AXI_DATA_WIDTH  write data.
- req_strb_i  input  AXI_DATA_WIDTH/8  write strobes.
- rsp_valid_o  output  1  one-cycle response pulse; no backpressure.
- rsp_rdata_o  output  AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_err_o  output  1  error qualifier for rsp_valid_o.
- m_axi_awid/awaddr/awvalid  output  ID/ADDR/1  write address channel.
- m_axi_awready  input  1.
- m_axi_wdata/wstrb/wlast/wvalid  output  DATA/DATA/8/1/1  write data; wlast is constant 1.
- m_axi_wready  input  1.
- m_axi_bid/bresp/bvalid  input  ID/2/1  write response.
- m_axi_bready  output  1.
- m_axi_arid/araddr/arvalid  output  ID/ADDR/1  read address channel.
- m_axi_arready  input  1.
- m_axi_rid/rdata/rresp/rlast/rvalid  input  ID/DATA/2/1/1  read data.
- m_axi_rready  output  1.
- m_axi_{aw,ar}{len,size,burst,lock,cache,prot,qos,region,user}, m_axi_wuser  output  constants: len=0, size=log2(DATA/8), burst=INCR(01), cache=0010, all others 0.

Behaviour:
- FSM states: IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R, RESP, DRAIN (DRAIN only with the optional feature).
- Reset values: all valid and ready outputs 0 except req_ready_o=1; rsp_rdata_o=0; rsp_err_o=0; state=IDLE.
- req_ready_o=1 only in IDLE. On accept, capture addr/wdata/strb/we.
- Write accept: awvalid and wvalid both assert the next cycle. Per-channel done flags clear each valid independently on its ready; awready and wready in the same cycle are allowed. When both flags are set, go to WAIT_B.
- Read accept: arvalid asserts the next cycle; arready moves to WAIT_R.
- A valid never drops before its ready (AXI rule); address and data stay stable while valid.
- WAIT_B: bready=1. On bvalid, err = bresp[1] | (bid!=TXN_ID). Go to RESP.
- WAIT_R: rready=1. On rvalid, capture rdata; err = rresp[1] | !rlast | (rid!=TXN_ID). Go to RESP.
- RESP: rsp_valid_o=1 for exactly one cycle, then IDLE. rsp_err_o and rsp_rdata_o hold their values until the next RESP.
- Minimum latency, zero-wait slave: accept at cycle 0 → handshake at cycle 1 → response at cycle 2 → rsp_valid_o at cycle 3. The next request can be accepted at cycle 4.
- EXOKAY (01) is treated as success.
- Reset mid-operation: the next cycle all valids are 0 and state=IDLE. The slave and interconnect must share the same reset.

Optional Feature:
- Macro: AXI_SINGLE_BEAT_MASTER_TIMEOUT_EN.
- When defined: a counter clears on entry to WAIT_B/WAIT_R and increments each cycle there. When it reaches TIMEOUT_CYCLES-1 without a response:
  - go to RESP with rsp_err_o=1 and rsp_rdata_o=0;
  - then go to DRAIN, which holds bready/rready=1 and req_ready_o=0 until one late response is consumed, then IDLE.
- Address/data phases are never timed out.
- When undefined: no counter, no DRAIN state; the block waits indefinitely.

Decomposition:
- Package axi_single_beat_master_pkg holds:
  - state enum;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - BURST_INCR and CACHE_MODIFIABLE constants;
  - a size function of data width.
- No sub-module; the optional timeout counter is inline.

Test Plan:
- Write addr 0x0200_4000, data 0x1122334455667788, strb 0xFF; zero-wait slave, bresp=00 → one AW, one W with wlast=1, rsp_valid at cycle 3, err=0.
- Read 0x0C00_0004; slave returns rdata 0xDEADBEEF, rresp=00, rlast=1 → rsp_rdata=0xDEADBEEF, err=0; arlen=0, arsize=3.
- Write with wready asserted 5 cycles after awready → awvalid drops after its handshake, wvalid stays high until its handshake, exactly one response.
- Read with rresp=10, then a write with bid≠TXN_ID → err=1 for both; rdata=0 on the write response.
- Assert aresetn=0 for 1 cycle during WAIT_B → next cycle all valids 0, req_ready=1, no rsp_valid.
- With the timeout macro and TIMEOUT_CYCLES=16, slave never returns R → err pulse after 16 cycles in WAIT_R; a late rvalid is absorbed in DRAIN; req_ready returns to 1 after it.
